regg_load: RTL and testbench

Load-side pipeline for the register/memory datapath: the reader that brings data back from the 256×16 data memory into the 16×16 register bank, the reverse direction of the ALU/store pipeline. Each accepted instruction reads `mem[addr]` and, for some ops, combines it with `regbank[rs]`. It then writes the 16-bit result to `regbank[rd]` and reports it on a one-cycle output strobe. The block has a single clock and three stages with read-after-write hazard handling, and owns both storage arrays. It exposes a memory fill port and a register debug read port.

---
 rtl/regg_pkg.sv | 24 ++
 rtl/regg_load_alu.sv | 28 ++
 rtl/regg_load.sv | 122 ++++++++++++
 tb/tb_regg_load.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regg_pkg.sv
// Shared constants and helpers for the regg_load pipeline.
// Op codes, datapath widths and the op-group classification.
package regg_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;
    localparam int REG_W  = 4;
    localparam int OP_W   = 4;

    localparam logic [OP_W-1:0] OP_LD    = 4'd0;
    localparam logic [OP_W-1:0] OP_LDADD = 4'd1;
    localparam logic [OP_W-1:0] OP_LDSUB = 4'd2;
    localparam logic [OP_W-1:0] OP_LDAND = 4'd3;
    localparam logic [OP_W-1:0] OP_LDOR  = 4'd4;
    localparam logic [OP_W-1:0] OP_LDXOR = 4'd5;
    localparam logic [OP_W-1:0] OP_LDSHR = 4'd6;
    localparam logic [OP_W-1:0] OP_LDNEG = 4'd7;

    // Only the two-operand ops read regbank[rs]; everything else ignores it.
    function automatic logic op_uses_rs(input logic [OP_W-1:0] op);
        return (op >= OP_LDADD) && (op <= OP_LDXOR);
    endfunction

endpackage

// File: rtl/regg_load_alu.sv
// Combinational result unit for regg_load: (op, M, R) -> 16-bit result.
// Undefined op codes produce zero.
module regg_load_alu
    import regg_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] m,
    input  logic [DATA_W-1:0] r,
    output logic [DATA_W-1:0] result
);

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves result unassigned (no latch).
        result = '0;
        case (op)
            OP_LD:    result = m;
            OP_LDADD: result = m + r;
            OP_LDSUB: result = m - r;
            OP_LDAND: result = m & r;
            OP_LDOR:  result = m | r;
            OP_LDXOR: result = m ^ r;
            OP_LDSHR: result = m >> 1;
            OP_LDNEG: result = -m;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/regg_load.sv
// Load-side pipeline (F/X/W) owning the 256x16 data memory and 16x16 register bank.
// Define REGG_LOAD_FWD_EN to forward x_result on a RAW hazard instead of stalling one cycle.
module regg_load
    import regg_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OP_W-1:0]     op,
    input  logic [REG_W-1:0]    rs,
    input  logic [REG_W-1:0]    rd,
    input  logic [ADDR_W-1:0]   addr,
    input  logic                mem_we,
    input  logic [ADDR_W-1:0]   mem_waddr,
    input  logic [DATA_W-1:0]   mem_wdata,
    output logic                out_valid,
    output logic [REG_W-1:0]    out_rd,
    output logic [DATA_W-1:0]   out_data,
    input  logic [REG_W-1:0]    dbg_raddr,
    output logic [DATA_W-1:0]   dbg_rdata
);

    logic [DATA_W-1:0] mem     [256];
    logic [DATA_W-1:0] regbank [16];

    logic              f_valid;
    logic [OP_W-1:0]   f_op;
    logic [REG_W-1:0]  f_rs;
    logic [REG_W-1:0]  f_rd;
    logic [DATA_W-1:0] f_m;

    logic              x_valid;
    logic [REG_W-1:0]  x_rd;
    logic [DATA_W-1:0] x_result;

    logic              hazard;
    logic              stall;
    logic              accept;
    logic [DATA_W-1:0] operand_r;
    logic [DATA_W-1:0] alu_result;

    // The instruction in X has not reached the bank yet, so F would read a stale R.
    assign hazard = f_valid && x_valid && op_uses_rs(f_op) && (x_rd == f_rs);

`ifdef REGG_LOAD_FWD_EN
    assign stall     = 1'b0;
    assign operand_r = hazard ? x_result : regbank[f_rs];
`else
    assign stall     = hazard;
    assign operand_r = regbank[f_rs];
`endif

    assign in_ready  = !rst && !stall;
    assign accept    = in_valid && in_ready;
    assign dbg_rdata = regbank[dbg_raddr];

    regg_load_alu u_alu (
        .op     (f_op),
        .m      (f_m),
        .r      (operand_r),
        .result (alu_result)
    );

    // NOTE: the data memory is deliberately left out of reset; fills must land even on the reset edge.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                regbank[i] <= '0;
            end
        end else if (x_valid) begin
            regbank[x_rd] <= x_result;
        end
    end

    // NOTE: non-blocking assignments so each stage samples the previous stage's pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            f_valid   <= 1'b0;
            f_op      <= '0;
            f_rs      <= '0;
            f_rd      <= '0;
            f_m       <= '0;
            x_valid   <= 1'b0;
            x_rd      <= '0;
            x_result  <= '0;
            out_valid <= 1'b0;
            out_rd    <= '0;
            out_data  <= '0;
        end else begin
            if (!stall) begin
                f_valid <= accept;
                if (accept) begin
                    f_m  <= mem[addr];
                    f_op <= op;
                    f_rs <= rs;
                    f_rd <= rd;
                end
            end

            // A stalled F holds its contents and X takes a bubble while the older result retires.
            x_valid <= f_valid && !stall;
            if (f_valid && !stall) begin
                x_rd     <= f_rd;
                x_result <= alu_result;
            end

            out_valid <= x_valid;
            if (x_valid) begin
                out_rd   <= x_rd;
                out_data <= x_result;
            end
        end
    end

endmodule

// File: tb/tb_regg_load.sv
// Self-checking bench for regg_load: directed scenarios plus randomized traffic
// scored against a program-order model of the register bank, memory and output timing.
module tb_regg_load;

`ifdef REGG_LOAD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op = '0;
    logic [3:0]  rs = '0;
    logic [3:0]  rd = '0;
    logic [7:0]  addr = '0;
    logic        mem_we = 1'b0;
    logic [7:0]  mem_waddr = '0;
    logic [15:0] mem_wdata = '0;
    logic        out_valid;
    logic [3:0]  out_rd;
    logic [15:0] out_data;
    logic [3:0]  dbg_raddr = '0;
    logic [15:0] dbg_rdata;

    always #5 clk = ~clk;

    regg_load dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rs        (rs),
        .rd        (rd),
        .addr      (addr),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .out_valid (out_valid),
        .out_rd    (out_rd),
        .out_data  (out_data),
        .dbg_raddr (dbg_raddr),
        .dbg_rdata (dbg_rdata)
    );

    typedef struct {
        logic [3:0]  rd;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] mdl_mem [256];
    logic [15:0] mdl_reg [16];
    int          edge_cnt    = 0;
    int          vectors     = 0;
    int          miscompares = 0;
    int          prev_x      = -10;
    int          stall_cyc   = -1;
    logic [3:0]  prev_rd     = '0;
    bit          have_prev   = 1'b0;

    always @(posedge clk) edge_cnt++;

    // Output monitor: out_valid must pulse exactly on the predicted cycle with the model's result.
    always @(negedge clk) begin : monitor
        bit exp_v;
        while (exp_q.size() > 0 && exp_q[0].cyc < edge_cnt) void'(exp_q.pop_front());
        exp_v = (exp_q.size() > 0) && (exp_q[0].cyc == edge_cnt);
        vectors++;
        if (out_valid !== exp_v) begin
            miscompares++;
            $display("FAIL out_valid cycle %0d: got %b want %b", edge_cnt, out_valid, exp_v);
        end else if (exp_v) begin
            vectors++;
            if (out_rd !== exp_q[0].rd || out_data !== exp_q[0].data) begin
                miscompares++;
                $display("FAIL out_result cycle %0d: got rd=%0d data=%h want rd=%0d data=%h",
                         edge_cnt, out_rd, out_data, exp_q[0].rd, exp_q[0].data);
            end
            void'(exp_q.pop_front());
        end
    end

    function automatic logic [15:0] ref_result(input logic [3:0] o, input logic [15:0] m,
                                               input logic [15:0] r);
        logic [15:0] res;
        case (o)
            4'd0:    res = m;
            4'd1:    res = m + r;
            4'd2:    res = m - r;
            4'd3:    res = m & r;
            4'd4:    res = m | r;
            4'd5:    res = m ^ r;
            4'd6:    res = m / 2;
            4'd7:    res = 16'd0 - m;
            default: res = 16'd0;
        endcase
        return res;
    endfunction

    // Program-order model: result from the bank as all earlier instructions left it,
    // plus the expected X-entry edge (one extra edge when a non-forwarding RAW stall applies).
    task automatic model_accept(input logic [3:0] o, input logic [3:0] s, input logic [3:0] d,
                                input logic [7:0] a);
        logic [15:0] res;
        int          a_edge;
        bit          stl;
        res        = ref_result(o, mdl_mem[a], mdl_reg[s]);
        mdl_reg[d] = res;
        a_edge     = edge_cnt + 1;
        stl        = !FWD && have_prev && (prev_x == a_edge) && (o >= 4'd1) && (o <= 4'd5)
                     && (prev_rd == s);
        if (stl) stall_cyc = a_edge;
        prev_x    = a_edge + 1 + (stl ? 1 : 0);
        prev_rd   = d;
        have_prev = 1'b1;
        exp_q.push_back('{rd: d, data: res, cyc: prev_x + 1});
    endtask

    task automatic model_flush();
        exp_q.delete();
        have_prev = 1'b0;
        stall_cyc = -1;
        for (int i = 0; i < 16; i++) mdl_reg[i] = 16'd0;
    endtask

    // Called in the low clock phase; returns at negedge+1 after acceptance.
    task automatic issue(input logic [3:0] o, input logic [3:0] s, input logic [3:0] d,
                         input logic [7:0] a, input bit fw = 1'b0,
                         input logic [7:0] fa = 8'd0, input logic [15:0] fd = 16'd0);
        int   tries = 0;
        bit   fill_pend;
        bit   acc;
        logic exp_rdy;
        fill_pend = fw;
        in_valid  = 1'b1;
        op = o; rs = s; rd = d; addr = a;
        mem_we = fw; mem_waddr = fa; mem_wdata = fd;
        forever begin
            #1;
            exp_rdy = (edge_cnt != stall_cyc);
            vectors++;
            if (in_ready !== exp_rdy) begin
                miscompares++;
                $display("FAIL in_ready cycle %0d: got %b want %b", edge_cnt, in_ready, exp_rdy);
            end
            acc = (in_ready === 1'b1);
            if (acc) model_accept(o, s, d, a);
            if (fill_pend) begin
                mdl_mem[fa] = fd;
                fill_pend   = 1'b0;
            end
            @(negedge clk); #1;
            mem_we = 1'b0;
            if (acc) break;
            tries++;
            if (tries > 4) begin
                vectors++;
                miscompares++;
                $display("FAIL accept_timeout cycle %0d: got no accept want accept", edge_cnt);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic fill(input logic [7:0] a, input logic [15:0] d);
        mem_we = 1'b1; mem_waddr = a; mem_wdata = d;
        @(negedge clk); #1;
        mem_we     = 1'b0;
        mdl_mem[a] = d;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        if (exp_q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: got %0d pending results want 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk); #1;
    endtask

    task automatic check_reg_const(input logic [3:0] i, input logic [15:0] want, input string tag);
        dbg_raddr = i;
        #1;
        vectors++;
        if (dbg_rdata !== want) begin
            miscompares++;
            $display("FAIL %s r%0d: got %h want %h", tag, i, dbg_rdata, want);
        end
        @(negedge clk); #1;
    endtask

    task automatic check_regs(input string tag);
        drain();
        for (int i = 0; i < 16; i++) begin
            dbg_raddr = 4'(i);
            #1;
            vectors++;
            if (dbg_rdata !== mdl_reg[i]) begin
                miscompares++;
                $display("FAIL %s r%0d: got %h want %h", tag, i, dbg_rdata, mdl_reg[i]);
            end
            @(negedge clk); #1;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b want 0", in_ready);
        end
        vectors++;
        if (out_valid !== 1'b0 || out_rd !== 4'd0 || out_data !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got v=%b rd=%0d data=%h want 0 0 0000",
                     out_valid, out_rd, out_data);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL idle_in_ready: got %b want 1", in_ready);
        end
        model_flush();
        @(negedge clk); #1;
        check_regs("reset_regs");
    endtask

    task automatic test_mem_init();
        for (int i = 0; i < 256; i++) fill(8'(i), 16'($urandom));
    endtask

    task automatic test_basic_load();
        fill(8'd125, 16'h0042);
        issue(4'd0, 4'd0, 4'd3, 8'd125);
        drain();
        check_reg_const(4'd3, 16'h0042, "basic_load");
    endtask

    task automatic test_wrap();
        fill(8'd10, 16'h0001);
        fill(8'd11, 16'h0000);
        fill(8'd12, 16'h0003);
        issue(4'd0, 4'd0, 4'd5, 8'd12);
        drain();
        issue(4'd2, 4'd5, 4'd6, 8'd10);
        issue(4'd7, 4'd0, 4'd7, 8'd11);
        drain();
        check_reg_const(4'd6, 16'hFFFE, "wrap_sub");
        check_reg_const(4'd7, 16'h0000, "wrap_neg");
    endtask

    task automatic test_back_to_back();
        fill(8'd0, 16'd7);
        fill(8'd1, 16'd5);
        issue(4'd0, 4'd0, 4'd2, 8'd0);
        issue(4'd1, 4'd2, 4'd4, 8'd1);
        issue(4'd1, 4'd4, 4'd4, 8'd1);
        drain();
        check_reg_const(4'd4, 16'd17, "hazard_chain");
        check_reg_const(4'd2, 16'd7, "hazard_src");
    endtask

    task automatic test_fill_collision();
        fill(8'd20, 16'd1);
        issue(4'd0, 4'd0, 4'd1, 8'd20, 1'b1, 8'd20, 16'd9);
        drain();
        check_reg_const(4'd1, 16'd1, "collision_old");
        issue(4'd0, 4'd0, 4'd1, 8'd20);
        drain();
        check_reg_const(4'd1, 16'd9, "collision_new");
    endtask

    task automatic test_illegal_op();
        fill(8'd30, 16'h1234);
        issue(4'd0, 4'd0, 4'd9, 8'd30);
        drain();
        check_reg_const(4'd9, 16'h1234, "illegal_pre");
        issue(4'd12, 4'd9, 4'd9, 8'd30);
        drain();
        check_reg_const(4'd9, 16'h0000, "illegal_op");
    endtask

    task automatic test_reset_midflight();
        issue(4'd0, 4'd0, 4'd8, 8'd40);
        issue(4'd0, 4'd0, 4'd9, 8'd41);
        // Reset lands on the edge where the first result would have retired.
        rst = 1'b1;
        mem_we = 1'b1; mem_waddr = 8'd200; mem_wdata = 16'hBEEF;
        model_flush();
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL midflight_in_ready: got %b want 0", in_ready);
        end
        @(negedge clk); #1;
        rst = 1'b0;
        mem_we = 1'b0;
        mdl_mem[200] = 16'hBEEF;
        repeat (3) begin
            @(negedge clk); #1;
        end
        check_regs("midflight_regs");
        issue(4'd0, 4'd0, 4'd1, 8'd200);
        drain();
        check_reg_const(4'd1, 16'hBEEF, "reset_edge_fill");
    endtask

    task automatic test_random();
        logic [3:0]  o, s, d;
        logic [7:0]  a, fa;
        logic [15:0] fd;
        bit          fw;
        for (int n = 0; n < 400; n++) begin
            o  = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 7));
            s  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            d  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            a  = 8'($urandom_range(0, 255));
            fw = ($urandom_range(0, 5) == 0);
            fa = ($urandom_range(0, 1) == 0) ? a : 8'($urandom_range(0, 255));
            fd = 16'($urandom);
            issue(o, s, d, a, fw, fa, fd);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk); #1;
            end
        end
        check_regs("random_regs");
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_mem_init();
        test_basic_load();
        test_wrap();
        test_back_to_back();
        test_fill_collision();
        test_illegal_op();
        test_reset_midflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
